// File: rtl/disp_pkg.sv
// Shared types and helpers for the FIFO display reader: read-FSM states,
// blank segment value and the hex-to-7-segment table.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2
    } rd_state_t;

    // All segments off in active-high terms; polarity applied by seg_off()
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg_off(input logic act_low);
        return act_low ? ~SEG_BLANK : SEG_BLANK;
    endfunction

    // Segment order {dp,g,f,e,d,c,b,a}; dp is never lit
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic act_low);
        logic [7:0] seg;
        case (nibble)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return act_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner: rotates a one-hot digit enable every
// SCAN_DIV cycles and presents the matching segment slice alongside it.
module seg_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SCAN_DIV    = 250,
    parameter int unsigned SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*8-1:0]   seg_static,
    output logic [7:0]            seg_scan,
    output logic [DIGITS-1:0]     dig_en
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0]  BLANK = seg_off(SEG_ACT_LOW != 0);

    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic             div_tc;

    assign div_tc = (div_cnt == DIV_W'(SCAN_DIV - 1));

    // Slot divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_tc) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Enable and segments share one register stage so they switch together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_en   <= DIGITS'(1);
            seg_scan <= BLANK;
        end else begin
            dig_en   <= DIGITS'(1) << idx;
            seg_scan <= seg_static[{idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/fifo_disp_reader.sv
// Paced FIFO read engine with hex display drivers: pops words under run/step
// control, holds each for HOLD_CYCLES, and renders the last word as 7-segment.
module fifo_disp_reader
    import disp_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned SCAN_MODE   = 0,
    parameter int unsigned SCAN_DIV    = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rempty,
    input  logic [DATA_W-1:0]       rdata,
    output logic                    rinc,
    input  logic                    run,
    input  logic                    step,
    output logic [DATA_W-1:0]       data_out,
    output logic                    valid_out,
    output logic [15:0]             word_cnt,
    output logic [DATA_W/4*8-1:0]   seg_static,
    output logic [7:0]              seg_scan,
    output logic [DATA_W/4-1:0]     dig_en
);

    localparam int unsigned DIGITS = DATA_W / 4;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [7:0]  BLANK  = seg_off(SEG_ACT_LOW != 0);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              step_pend;
    logic              go;
    logic              pop_enter;

    assign go = run | step_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go && !rempty) state_nxt = POP;
            POP:     state_nxt = HOLD;
            HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop decision is taken on the IDLE->POP edge so rinc can be registered
    always_comb begin
        pop_enter = 1'b0;
        if (state == IDLE && state_nxt == POP) pop_enter = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rinc      <= 1'b0;
            data_out  <= '0;
            valid_out <= 1'b0;
            word_cnt  <= '0;
            step_pend <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            rinc <= pop_enter;
            if (pop_enter) begin
                data_out  <= rdata;
                valid_out <= 1'b1;
                word_cnt  <= word_cnt + 16'd1;
            end
            // Clearing on pop wins, so a step arriving with the pop is absorbed
            if (pop_enter)         step_pend <= 1'b0;
            else if (step && !run) step_pend <= 1'b1;
            if (state == POP)
                hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_static <= {DIGITS{BLANK}};
        end else begin
            for (int k = 0; k < DIGITS; k++)
                seg_static[8*k +: 8] <= valid_out
                    ? hex_to_seg(data_out[4*k +: 4], SEG_ACT_LOW != 0) : BLANK;
        end
    end

    if (SCAN_MODE != 0) begin : g_scan
        seg_scan_mux #(
            .DIGITS      (DIGITS),
            .SCAN_DIV    (SCAN_DIV),
            .SEG_ACT_LOW (SEG_ACT_LOW)
        ) u_scan (
            .clk        (clk),
            .rst        (rst),
            .seg_static (seg_static),
            .seg_scan   (seg_scan),
            .dig_en     (dig_en)
        );
    end else begin : g_static
        assign seg_scan = seg_static[7:0];
        assign dig_en   = '1;
    end

endmodule

// File: doc/fifo_disp_reader.md
Name: fifo_disp_reader

Overview:
- Parametrised successor to the fixed 16-bit FIFO read state machine plus per-nibble 7-segment drivers.
- Pops words from the read side of the async FIFO in the read clock domain, and paces pops with a programmable hold time.
- Supports free-run and single-step modes; counts consumed words.
- Drives either static per-digit segment buses or a time-multiplexed single segment bus with digit enables.

Parameters:
- DATA_W, 16, FIFO word width; must be a multiple of 4. Localparam DIGITS = DATA_W/4.
- HOLD_CYCLES, 1000, cycles each word is held before the next pop; minimum 1.
- SEG_ACT_LOW, 1, 1 = segment lines active-low, 0 = active-high.
- SCAN_MODE, 0, 0 = static buses only, 1 = multiplexed scan active.
- SCAN_DIV, 250, clk cycles per scan digit slot; minimum 1.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous reset, active-high.
- rempty  in  1  FIFO empty flag, synchronous to clk.
- rdata  in  DATA_W  FIFO head word; valid whenever rempty=0.
- rinc  out  1  FIFO pop strobe, registered.
- run  in  1  level; 1 = pop continuously.
- step  in  1  single-cycle pulse; requests exactly one pop while run=0.
- data_out  out  DATA_W  last popped word.
- valid_out  out  1  set at the first pop, stays set until reset.
- word_cnt  out  16  number of pops; wraps FFFF->0000.
- seg_static  out  DIGITS*8  per-digit segments; digit k in bits [8k+7:8k], digit 0 = least significant nibble.
- seg_scan  out  8  multiplexed segments.
- dig_en  out  DIGITS  one-hot digit enable, active-high.

Behaviour:
- Reset (async, any state): state=IDLE, rinc=0, data_out=0, valid_out=0, word_cnt=0, step_pend=0.
  - seg_static and seg_scan = blank (all segments off: 8'hFF if SEG_ACT_LOW, else 8'h00).
  - Scan index=0, dig_en=1 if SCAN_MODE=1, else all ones.
- Segment encoding: bits {dp,g,f,e,d,c,b,a}; dp always off. Active-high values: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. When SEG_ACT_LOW=1, each value is inverted.
- go = run | step_pend.
- step_pend:
  - Set on step=1 while run=0.
  - Cleared on entry to POP.
  - Repeated steps while it is pending collapse into one pop.
  - step is ignored while run=1.
- FSM:
  - IDLE: if go and !rempty -> POP. On this edge, data_out<=rdata and valid_out<=1.
  - POP: rinc=1 for exactly this cycle; word_cnt increments. Next state is HOLD, with hold counter loaded to HOLD_CYCLES-1.
  - HOLD: counter decrements each cycle; at 0 -> IDLE. The FIFO has no effect on HOLD.
- rinc is high only in POP. It is never high while rempty was 1 at the IDLE decision.
- Back-to-back pop period with the FIFO never empty and run=1 is HOLD_CYCLES+2 cycles.
- An empty FIFO stalls the FSM in IDLE indefinitely; data_out and the displays hold their last value.
- Dropping run mid-HOLD completes the current hold, then the FSM waits in IDLE.
- seg_static is registered from data_out, giving 1 cycle latency after data_out changes. It stays blank until valid_out=1.
- Scan (SCAN_MODE=1):
  - A divider counts 0..SCAN_DIV-1. At terminal count the digit index advances, wrapping DIGITS-1 -> 0.
  - dig_en = one-hot of the index; seg_scan = the seg_static slice at the index. Both are registered together, so there is no glitch between them.
- With SCAN_MODE=0, the scan logic is absent: seg_scan = digit 0 slice and dig_en = all ones.

Decomposition:
- Shared package disp_pkg:
  - Read-FSM state enum (IDLE, POP, HOLD).
  - SEG_BLANK constant.
  - Function hex_to_seg(nibble, act_low) containing the 16-entry table.
- Sub-module seg_scan_mux (parameters DIGITS, SCAN_DIV, SEG_ACT_LOW):
  - Contains the divider, index counter, dig_en and seg_scan registers.
  - Instantiated only under generate when SCAN_MODE=1.

Test Plan:
- Reset, then FIFO holds 16'h12AF, run=1, HOLD_CYCLES=4 -> rinc pulses once at cycle 2; data_out=12AF; word_cnt=1. Next cycle, seg_static={06,5B,77,71} inverted (F9,A4,88,8E) with digit 3 in the MSB.
- Three words queued, run=1, HOLD_CYCLES=4 -> rinc pulses exactly 6 cycles apart; word_cnt=3. rempty rises, no further rinc, and data_out holds the third word.
- run=0 with two words queued, step pulsed twice within one HOLD window -> only one pop. A third step after the FSM returns to IDLE -> a second pop.
- Assert rst during HOLD with rinc history -> all outputs return to their reset values asynchronously. After release, no pop occurs until go and !rempty.
- SCAN_MODE=1, SCAN_DIV=3, DATA_W=16 -> dig_en cycles 0001,0010,0100,1000,0001 every 3 cycles, with seg_scan matching the corresponding digit slice.
- Preload word_cnt to FFFF, then one pop -> word_cnt=0000 and valid_out stays 1.
